// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : iter_shifter
// Purpose  : Multi-cycle rotate/shift unit, up to STEP bits per clock,
//            valid/ready handshake on both sides.
// Revision : 1.0
// ============================================================================
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest step that can ever be needed; STEP=WIDTH saturates to WIDTH-1.
    localparam logic [AMT_W-1:0] STEP_AMT = (STEP >= WIDTH) ? AMT_W'(WIDTH - 1)
                                                            : AMT_W'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AMT_W-1:0] rem_q,   rem_d;
    logic [2:0]       op_q,    op_d;

    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        step_amt = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        shifted  = data_q;
        casez (op_q)
            3'b000:  shifted = (data_q << step_amt) | (data_q >> (WIDTH - int'(step_amt)));
            3'b001:  shifted = data_q << step_amt;
            3'b010:  shifted = (data_q >> step_amt) | (data_q << (WIDTH - int'(step_amt)));
            3'b011:  shifted = data_q >> step_amt;
            default: shifted = $signed(data_q) >>> step_amt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_amt;
                    op_d    = in_op;
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_data  = data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_shifter
// Purpose  : Self-checking bench for iter_shifter (STEP=1 and STEP=4 instances).
// Revision : 1.0
// ============================================================================
module tb_iter_shifter;

    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_op;

    logic          iv1, ir1, ov1, or1, bz1;
    logic          iv4, ir4, ov4, or4, bz4;
    logic [W-1:0]  od1, od4;
    logic          in_ready_m, out_valid_m, busy_m;
    logic [W-1:0]  out_data_m;

    always #5 clk = ~clk;

    assign iv1         = in_valid & ~sel;
    assign iv4         = in_valid & sel;
    assign or1         = out_ready & ~sel;
    assign or4         = out_ready & sel;
    assign in_ready_m  = sel ? ir4 : ir1;
    assign out_valid_m = sel ? ov4 : ov1;
    assign busy_m      = sel ? bz4 : bz1;
    assign out_data_m  = sel ? od4 : od1;

    iter_shifter #(.WIDTH(W), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(bz1)
    );

    iter_shifter #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(bz4)
    );

    typedef struct {
        logic          s;
        logic [2:0]    op;
        logic [W-1:0]  data;
        logic [AW-1:0] amt;
        logic [W-1:0]  exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        int           n;
        string        name;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[10];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: apply the single-bit operation amt times.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] d, input int amt);
        logic [W-1:0] r;
        r = d;
        for (int k = 0; k < amt; k++) begin
            casez (op)
                3'b000:  r = {r[W-2:0], r[W-1]};
                3'b001:  r = {r[W-2:0], 1'b0};
                3'b010:  r = {r[0], r[W-1:1]};
                3'b011:  r = {1'b0, r[W-1:1]};
                default: r = {r[W-1], r[W-1:1]};
            endcase
        end
        return r;
    endfunction

    function automatic int cycles_for(input logic s, input logic [AW-1:0] amt);
        return s ? (int'(amt) + 3) / 4 : int'(amt);
    endfunction

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic issue(input logic s, input logic [2:0] op, input logic [W-1:0] data,
                         input logic [AW-1:0] amt, input logic [W-1:0] exp, input string name);
        sel = s;
        #1;
        chk({name, " in_ready"}, 32'(in_ready_m), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_amt   = amt;
        sbq.push_back('{exp, cycles_for(s, amt), name});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit rel);
        sb_t e;
        int  cyc;
        cyc = 0;
        if (sbq.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        chk({e.name, " busy"}, 32'(busy_m), 32'd1);
        while (!out_valid_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({e.name, " latency"}, 32'(cyc), 32'(e.n));
        chk({e.name, " data"}, 32'(out_data_m), 32'(e.exp));
        if (rel) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({e.name, " in_ready after release"}, 32'(in_ready_m), 32'd1);
        end
    endtask

    initial begin
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = 3'b000;

        vt[0] = '{1'b0, 3'b000, 16'h8001, 4'd1,  16'h0003};
        vt[1] = '{1'b0, 3'b011, 16'h8000, 4'd15, 16'h0001};
        vt[2] = '{1'b0, 3'b100, 16'h8000, 4'd4,  16'hF800};
        vt[3] = '{1'b0, 3'b010, 16'h0001, 4'd0,  16'h0001};
        vt[4] = '{1'b1, 3'b001, 16'h1234, 4'd7,  16'h1A00};
        vt[5] = '{1'b1, 3'b000, 16'hABCD, 4'd8,  16'hCDAB};
        vt[6] = '{1'b1, 3'b111, 16'h8000, 4'd15, 16'hFFFF};
        vt[7] = '{1'b1, 3'b010, 16'h0001, 4'd5,  16'h0800};
        vt[8] = '{1'b0, 3'b001, 16'h0001, 4'd15, 16'h8000};
        vt[9] = '{1'b1, 3'b011, 16'hF000, 4'd3,  16'h1E00};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset out_valid", 32'(out_valid_m), 32'd0);
            chk("reset out_data",  32'(out_data_m),  32'd0);
            chk("reset busy",      32'(busy_m),      32'd0);
            chk("reset in_ready",  32'(in_ready_m),  32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vt[i].s, vt[i].op, vt[i].data, vt[i].amt, vt[i].exp, $sformatf("vec%0d", i));
            collect(1'b1);
        end

        for (int i = 0; i < 24; i++) begin
            logic          s;
            logic [2:0]    op;
            logic [W-1:0]  d;
            logic [AW-1:0] a;
            s  = 1'($urandom_range(1));
            op = 3'($urandom_range(7));
            d  = 16'($urandom);
            a  = 4'($urandom_range(15));
            issue(s, op, d, a, model(op, d, int'(a)), $sformatf("rnd%0d", i));
            collect(1'b1);
        end

        // Backpressure with a competing request held on the input.
        issue(1'b0, 3'b000, 16'h8001, 4'd1, 16'h0003, "bp rol");
        collect(1'b0);
        in_valid = 1'b1;
        in_op    = 3'b001;
        in_data  = 16'h00FF;
        in_amt   = 4'd4;
        repeat (5) begin
            @(negedge clk);
            chk("bp hold data",     32'(out_data_m),  32'h0003);
            chk("bp hold in_ready", 32'(in_ready_m),  32'd0);
            chk("bp hold valid",    32'(out_valid_m), 32'd1);
        end
        out_ready = 1'b1;
        sbq.push_back('{16'h0FF0, 4, "bp next"});
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp release in_ready", 32'(in_ready_m),  32'd1);
        chk("bp release valid",    32'(out_valid_m), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        collect(1'b1);

        // Reset during the fifth SHIFT cycle.
        issue(1'b0, 3'b011, 16'hFFFF, 4'd12, 16'h000F, "rst srl");
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid_m), 32'd0);
        chk("midrst out_data",  32'(out_data_m),  32'd0);
        chk("midrst busy",      32'(busy_m),      32'd0);
        chk("midrst in_ready",  32'(in_ready_m),  32'd1);
        sbq.delete(sbq.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'b011, 16'hFFFF, 4'd12, 16'h000F, "post rst srl");
        collect(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle barrel-shift unit for the execute stage. It takes a WIDTH-bit operand, a shift amount and an operation code, then shifts iteratively by up to STEP bit positions per clock. It supports rotate left, shift left logical, rotate right, shift right logical and shift right arithmetic. Operands enter through a valid/ready handshake and results leave through one, so the unit can sit behind a stallable pipeline register.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; power of two, ≥ 2.
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1..WIDTH.
- AMT_W (localparam), $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  the block's single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand, amount and op are valid.
- in_ready  output  1  unit can accept a new operation.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
- in_op  input  3  operation: 000 rol, 001 sll, 010 ror, 011 srl, 1xx sra.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  result.
- busy  output  1  high while in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1, out_valid=0, busy=0.
  - On in_valid: load data, remaining=in_amt and op.
  - Go to SHIFT if in_amt≠0, else DONE.
- SHIFT: each edge shifts the working register by s=min(STEP, remaining), then sets remaining -= s.
  - When remaining becomes 0, go to DONE.
  - in_ready=0 and in_valid is ignored.
- DONE: out_valid=1 and out_data=working register.
  - On out_ready, return to IDLE.
  - A new operation is not accepted in the same cycle; in_ready stays 0 in DONE.
- Per-op shift by s:
  - rol: bits leaving the MSB enter at the LSB.
  - ror: bits leaving the LSB enter at the MSB.
  - sll: zeros fill at the LSB.
  - srl: zeros fill at the MSB.
  - sra: copies of the current MSB fill at the MSB. This is new versus the 4-op single-bit stage.
- Results equal the single-shot shift by in_amt modulo width; for rotates, rotation by in_amt.
- Illegal amounts cannot occur, since AMT_W bits cover 0..WIDTH-1 exactly.
- out_data is only meaningful while out_valid=1. It holds the working register in every state.

## Timing
- Reset (async assert, sync deassert by the surrounding reset tree) gives:
  - state=IDLE, working register=0, remaining=0, op=000.
  - Outputs: out_valid=0, out_data=0, busy=0, in_ready=1.
- Accept edge T0 = first edge with in_valid && in_ready.
- With n=ceil(in_amt/STEP):
  - out_valid is visible from edge T0+n onward. This includes n=0, where it is visible in the cycle right after T0.
  - The state is SHIFT for exactly n cycles.
- Result is held stable, with out_valid high, for as long as out_ready=0. There is no timeout.
- Release: the edge with out_valid && out_ready returns to IDLE. in_ready is 1 in the following cycle.
- Minimum issue interval: n+2 cycles per operation.
- rst_n asserted mid-SHIFT or in DONE: the operation is discarded immediately. There is no partial result and no spurious out_valid.
- out_ready high while not in DONE: no effect.
- in_valid held across DONE→IDLE: accepted on the first IDLE edge.
- STEP=WIDTH: every nonzero amount completes in 1 SHIFT cycle.

## Test plan
- WIDTH=16, STEP=1. rol 0x8001, amt 1 → out_data 0x0003; out_valid rises 1 edge after accept.
- WIDTH=16, STEP=1. srl 0x8000, amt 15 → 0x0001 after 15 SHIFT cycles. sra 0x8000, amt 4 → 0xF800 after 4 cycles.
- ror 0x0001, amt 0 → 0x0001. out_valid is visible the cycle after accept and no SHIFT cycle occurs.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 and new data → out_data is stable, in_ready=0 and no second accept.
  - Release out_ready → IDLE; the next operation is accepted on the following edge.
- WIDTH=16, STEP=4. sll 0x1234, amt 7 → 0x1A00 after 2 SHIFT cycles. rol 0xABCD, amt 8 → 0xCDAB after 2 cycles.
- Reset mid-operation: srl 0xFFFF, amt 12, STEP=1. Pull rst_n low during cycle 5 of SHIFT → immediately out_valid=0, out_data=0, busy=0, in_ready=1. After release, the next operation completes correctly.
